clock_controller: RTL and testbench

Run/halt/step/burst sequencer for the CPU's free-running clock. Sits between the clock source and the CPU, generating a single clock-enable (`cpu_en`) that the CPU datapath qualifies every register update with. Lets the bench or front panel run continuously, single-step one cycle, run an exact burst of N cycles, or stop on a CPU halt request. Also keeps a count of enabled cycles.

---
 rtl/clock_controller.sv | 127 ++++++++++++
 tb/tb_clock_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clock_controller.sv
// Run/halt/step/burst clock-enable sequencer with enabled-cycle counter.
// Optional breakpoint compare is built when CLOCK_CONTROLLER_BREAKPOINT_EN is defined.
//
//   state  | meaning
//   HALTED | cpu_en low, accepting run/burst/step commands
//   RUN    | cpu_en high until halt or cpu_halt_req
//   STEP   | cpu_en high for exactly one cycle
//   BURST  | cpu_en high while remaining counts down to 1
module clock_controller #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               halt,
  input  logic               step,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cpu_halt_req,
`ifdef CLOCK_CONTROLLER_BREAKPOINT_EN
  input  logic [CNT_W-1:0]   bp_cycle,
  input  logic               bp_enable,
  output logic               bp_hit,
`endif
  output logic               cpu_en,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BURST  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] remaining_d;
  logic               stop;
  logic               bp_match;
  logic               bp_hit_d;

  assign state  = state_q;
  assign cpu_en = (state_q != HALTED);
  assign stop   = halt || cpu_halt_req;

`ifdef CLOCK_CONTROLLER_BREAKPOINT_EN
  // Compare against the count this enabled cycle will leave behind.
  assign bp_match = bp_enable && ((state_q == RUN) || (state_q == BURST)) &&
                    ((cycle_count + CNT_W'(1)) == bp_cycle);
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    bp_hit_d    = 1'b0;
    case (state_q)
      HALTED: begin
        if (halt) begin
          state_d = HALTED;
        end else if (run) begin
          state_d = RUN;
        end else if (burst_start && (burst_len != '0)) begin
          state_d     = BURST;
          remaining_d = burst_len;
        end else if (step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (stop || bp_match) begin
          state_d  = HALTED;
          bp_hit_d = bp_match && !stop;
        end
      end
      STEP: begin
        state_d = HALTED;
      end
      BURST: begin
        if (stop || bp_match || (remaining == BURST_W'(1))) begin
          state_d     = HALTED;
          remaining_d = '0;
          bp_hit_d    = bp_match && !stop;
        end else begin
          remaining_d = remaining - BURST_W'(1);
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HALTED;
      remaining   <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= remaining_d;
      if (cpu_en) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      done <= cpu_en && (state_d == HALTED);
    end
  end

`ifdef CLOCK_CONTROLLER_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit <= 1'b0;
    end else begin
      bp_hit <= bp_hit_d;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = bp_hit_d;
`endif

endmodule

// File: tb/tb_clock_controller.sv
// Scoreboard bench for clock_controller: a mode/cycles-left reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_clock_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, halt = 1'b0, step = 1'b0, burst_start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        cpu_halt_req = 1'b0;
  logic        cpu_en, done, cpu_en4, done4;
  logic [1:0]  state, state4;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count4;

  always #5 clk = ~clk;

  clock_controller #(.CNT_W(16), .BURST_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .step(step),
    .burst_start(burst_start), .burst_len(burst_len), .cpu_halt_req(cpu_halt_req),
    .cpu_en(cpu_en), .state(state), .cycle_count(cycle_count), .done(done)
  );

  // Narrow counter copy to observe wrap-around at 2^4.
  clock_controller #(.CNT_W(4), .BURST_W(8)) dut4 (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .step(step),
    .burst_start(burst_start), .burst_len(burst_len), .cpu_halt_req(cpu_halt_req),
    .cpu_en(cpu_en4), .state(state4), .cycle_count(cycle_count4), .done(done4)
  );

  typedef struct {
    logic      en;
    logic [1:0] st;
    int        cnt;
    logic      dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 idle, 1 free run, 2 single step, 3 counted burst.
  int m_mode = 0;
  int m_left = 0;
  int m_count = 0;
  bit m_done = 0;

  task automatic model_edge();
    exp_t e;
    int   nm;
    if (reset) begin
      m_mode = 0; m_left = 0; m_count = 0; m_done = 0;
    end else begin
      nm = m_mode;
      if (m_mode != 0) m_count = (m_count + 1) % 65536;
      case (m_mode)
        0: begin
          if (halt) nm = 0;
          else if (run) nm = 1;
          else if (burst_start && burst_len != 0) begin nm = 3; m_left = int'(burst_len); end
          else if (step) nm = 2;
        end
        1: if (halt || cpu_halt_req) nm = 0;
        2: nm = 0;
        default: begin
          m_left = m_left - 1;
          if (halt || cpu_halt_req || m_left == 0) begin nm = 0; m_left = 0; end
        end
      endcase
      m_done = (m_mode != 0) && (nm == 0);
      m_mode = nm;
    end
    e.en = (m_mode != 0);
    e.st = 2'(m_mode);
    e.cnt = m_count;
    e.dn = m_done;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("cpu_en", int'(cpu_en), int'(e.en));
      check("state", int'(state), int'(e.st));
      check("cycle_count", int'(cycle_count), e.cnt);
      check("done", int'(done), int'(e.dn));
      check("cycle_count_w4", int'(cycle_count4), e.cnt % 16);
      check("state_w4", int'(state4), int'(e.st));
    end
  end

  task automatic cyc(input bit r, input bit h, input bit s, input bit b,
                     input int len, input bit chr, input bit rst);
    @(negedge clk);
    run = r; halt = h; step = s; burst_start = b;
    burst_len = 8'(len); cpu_halt_req = chr; reset = rst;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    idle(20);
    // single step, then step held for four cycles
    cyc(0, 0, 1, 0, 0, 0, 0); idle(3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    // burst of 5, burst of 0, reset during a burst
    cyc(0, 0, 0, 1, 5, 0, 0); idle(8);
    cyc(0, 0, 0, 1, 0, 0, 0); idle(3);
    cyc(0, 0, 0, 1, 9, 0, 0); idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1); idle(3);
    // run for 10, run+halt together, cpu_halt_req stop
    cyc(1, 0, 0, 0, 0, 0, 0); idle(9);
    cyc(0, 1, 0, 0, 0, 0, 0); idle(2);
    cyc(1, 1, 0, 0, 0, 0, 0); idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0); idle(4);
    cyc(0, 0, 0, 0, 0, 1, 0); idle(2);
    // halt mid-burst, then back-to-back command in the done cycle
    cyc(0, 0, 0, 1, 20, 0, 0); idle(3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0); idle(3);
    // run 17 cycles to wrap the 4-bit counter
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0); idle(16);
    cyc(0, 1, 0, 0, 0, 0, 0); idle(2);
    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(15) == 0, $urandom_range(19) == 0, $urandom_range(7) == 0,
          $urandom_range(7) == 0, int'($urandom_range(12)), $urandom_range(29) == 0,
          $urandom_range(199) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
